// File: rtl/tree_route_scheduler.sv
// Shares one tree nearest-common-ancestor route unit among the P input ports of a tree router.
// Optional conflict-cycle statistics counter: define TREE_RT_SCHED_STAT_EN.
module tree_route_scheduler #(
    parameter int K = 2,
    parameter int L = 2,
    localparam int P    = K + 1,
    localparam int Kw   = (K > 1) ? $clog2(K) : 1,
    localparam int LKw  = L * Kw,
    localparam int Lw   = (L > 1) ? $clog2(L) : 1,
    localparam int DSPw = ((K + 1) > 1) ? $clog2(K + 1) : 1,
    localparam int Pw   = (P > 1) ? $clog2(P) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [LKw-1:0]      current_addr_encoded,
    input  logic [Lw-1:0]       current_level,
    input  logic [P-1:0]        req_i,
    input  logic [P*LKw-1:0]    dest_addr_i,
    output logic [P-1:0]        grant_o,
    output logic [P-1:0]        res_valid_o,
    output logic [P*DSPw-1:0]   res_port_o,
    input  logic [P-1:0]        consume_i,
    output logic [15:0]         stat_conflict_cnt_o
);

    logic [P-1:0]      r_res_valid;
    logic [P*DSPw-1:0] r_res_port;
    logic [P-1:0]      r_inflight;
    logic [Pw-1:0]     r_ptr;
    logic              r_s1_valid;
    logic [Pw-1:0]     r_s1_id;
    logic [LKw-1:0]    r_s1_addr;

    logic [P-1:0]      w_elig;
    logic [P-1:0]      w_grant;
    logic [P-1:0]      w_done;
    logic [Pw-1:0]     w_idx;
    logic [Pw-1:0]     w_win;
    logic [Pw-1:0]     w_ptr_nxt;
    logic [LKw-1:0]    w_win_addr;
    logic              w_any;
    logic              w_gnt_en;
    logic [DSPw-1:0]   w_route;

    // Up port unless every higher field of the destination agrees with this router's subtree.
    function automatic logic [DSPw-1:0] nca_route(
        input logic [LKw-1:0] cur,
        input logic [Lw-1:0]  lvl,
        input logic [LKw-1:0] dst
    );
        logic           mism;
        logic [Kw-1:0]  fld;
        mism = 1'b0;
        fld  = '0;
        for (int i = 1; i < L; i++) begin
            mism = mism | ((int'(lvl) < i) && (cur[(i-1)*Kw +: Kw] != dst[i*Kw +: Kw]));
        end
        for (int f = 0; f < L; f++) begin
            fld = (lvl == Lw'(f)) ? dst[f*Kw +: Kw] : fld;
        end
        return mism ? DSPw'(K) : DSPw'(fld);
    endfunction

    assign w_elig = req_i & ~r_res_valid & ~r_inflight;

    // Round-robin search from the priority pointer; grants are suppressed while in reset.
    always_comb begin
        w_idx      = '0;
        w_win      = '0;
        w_any      = 1'b0;
        w_grant    = '0;
        w_done     = '0;
        w_win_addr = '0;
        for (int i = 0; i < P; i++) begin
            w_idx = Pw'((int'(r_ptr) + i) % P);
            if (!w_any && w_elig[w_idx]) begin
                w_any = 1'b1;
                w_win = w_idx;
            end else begin
                w_any = w_any;
            end
        end
        w_gnt_en = w_any & reset;
        for (int p = 0; p < P; p++) begin
            w_grant[p] = w_gnt_en & (w_win == Pw'(p));
            w_done[p]  = r_s1_valid & (r_s1_id == Pw'(p));
            w_win_addr = (w_win == Pw'(p)) ? dest_addr_i[p*LKw +: LKw] : w_win_addr;
        end
        w_ptr_nxt = (w_win == Pw'(P - 1)) ? Pw'(0) : (w_win + Pw'(1));
    end

    assign w_route = nca_route(current_addr_encoded, current_level, r_s1_addr);

    // Pipeline, pointer, in-flight tracking and per-port result holding registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_res_valid <= '0;
            r_res_port  <= '0;
            r_inflight  <= '0;
            r_ptr       <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_id     <= '0;
            r_s1_addr   <= '0;
        end else begin
            r_s1_valid <= w_gnt_en;
            r_inflight <= (r_inflight & ~w_done) | w_grant;
            if (w_gnt_en) begin
                r_s1_id   <= w_win;
                r_s1_addr <= w_win_addr;
                r_ptr     <= w_ptr_nxt;
            end else begin
                r_s1_id   <= r_s1_id;
                r_s1_addr <= r_s1_addr;
                r_ptr     <= r_ptr;
            end
            for (int p = 0; p < P; p++) begin
                if (w_done[p]) begin
                    r_res_valid[p]               <= 1'b1;
                    r_res_port[p*DSPw +: DSPw]   <= w_route;
                end else if (consume_i[p]) begin
                    r_res_valid[p]               <= 1'b0;
                end else begin
                    r_res_valid[p]               <= r_res_valid[p];
                end
            end
        end
    end

    assign grant_o     = w_grant;
    assign res_valid_o = r_res_valid;
    assign res_port_o  = r_res_port;

`ifdef TREE_RT_SCHED_STAT_EN
    logic [15:0] r_stat;
    logic        w_multi;

    // Clearing the lowest set bit leaves something only when two or more ports are eligible.
    assign w_multi = |(w_elig & (w_elig - P'(1)));

    // Saturating conflict-cycle counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat <= 16'h0000;
        end else if (w_multi && (r_stat != 16'hFFFF)) begin
            r_stat <= r_stat + 16'h0001;
        end else begin
            r_stat <= r_stat;
        end
    end

    assign stat_conflict_cnt_o = r_stat;
`else
    assign stat_conflict_cnt_o = 16'h0000;
`endif

endmodule
